// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential 16/8 restoring divider.
package div_pkg;
  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and subtracts the divisor when it fits. Purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic         msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         qbit
);

  logic [W:0] t;
  logic [W:0] diff;

  // rem < divisor on entry, so t < 2*divisor and the difference fits in W bits.
  always_comb begin
    t        = {rem, msb};
    diff     = t - {1'b0, divisor};
    qbit     = (t >= {1'b0, divisor});
    rem_next = qbit ? diff[W-1:0] : t[W-1:0];
  end

endmodule

// File: rtl/seq_divider_16by8.sv
// 2W-by-W unsigned restoring divider, one quotient bit per clock; result after W clocks
// (errors after 1), held with out_valid until out_ready, then one idle bubble.
module seq_divider_16by8
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               err_div0,
  output logic               err_ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             out_valid_q, out_valid_d;
  logic             err_div0_q, err_div0_d;
  logic             err_ovf_q, err_ovf_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(.W(WIDTH)) u_step (
    .rem      (rem_q),
    .msb      (dq_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = out_valid_q;
    err_div0_d  = err_div0_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d     = DONE;
            err_div0_d  = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend[WIDTH-1:0];
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            state_d     = DONE;
            err_ovf_d   = 1'b1;
            quotient_d  = '1;
            remainder_d = '0;
          end else begin
            state_d = CALC;
            rem_d   = dividend[2*WIDTH-1:WIDTH];
            dq_d    = dividend[WIDTH-1:0];
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = {dq_q[WIDTH-2:0], step_qbit};
          remainder_d = step_rem;
        end
      end
      DONE: begin
        // Error results enter DONE with out_valid low; raise it one clock later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          err_div0_d  = 1'b0;
          err_ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
      err_div0_q  <= err_div0_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign err_div0  = err_div0_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed and random checks of seq_divider_16by8 against an arithmetic reference model.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        err_div0;
  logic        err_ovf;

  int checks = 0;
  int failures = 0;

  seq_divider_16by8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err_div0  (err_div0),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, compare against the model, optionally stall the consumer, then drain.
  task automatic run_op(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                        input int hold);
    int unsigned num, den, eq, er, elat, lat, w;
    logic ediv0, eovf;
    logic [7:0] q0, r0;
    num = 32'(dvd);
    den = 32'(dvs);
    ediv0 = 1'b0;
    eovf  = 1'b0;
    if (den == 0) begin
      ediv0 = 1'b1; eq = 255; er = num % 256; elat = 1;
    end else if (num / den > 255) begin
      eovf = 1'b1; eq = 255; er = 0; elat = 1;
    end else begin
      eq = num / den; er = num % den; elat = 8;
    end

    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);

    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);

    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quotient"}, 32'(quotient), eq);
    chk({tag, "_remainder"}, 32'(remainder), er);
    chk({tag, "_err_div0"}, 32'(err_div0), 32'(ediv0));
    chk({tag, "_err_ovf"}, 32'(err_ovf), 32'(eovf));
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    if (!ediv0 && !eovf) begin
      chk({tag, "_identity"}, 32'(quotient) * den + 32'(remainder), num);
      chk({tag, "_rem_lt_div"}, 32'(32'(remainder) < den), 32'd1);
    end

    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_quotient"}, 32'(quotient), 32'(q0));
      chk({tag, "_hold_remainder"}, 32'(remainder), 32'(r0));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end

    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_err"}, 32'({err_div0, err_ovf}), 32'd0);
    chk({tag, "_drain_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int unsigned rd, rh, rl;

    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outputs", 32'({out_valid, err_div0, err_ovf, quotient, remainder}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    run_op("t1", 16'h0064, 8'h07, 0);
    run_op("t2", 16'hFEFF, 8'hFF, 0);
    run_op("t3", 16'h1234, 8'h00, 0);
    run_op("t4", 16'h0800, 8'h08, 0);
    run_op("t4_next", 16'h0064, 8'h07, 0);
    run_op("t5", 16'h0064, 8'h07, 5);
    run_op("div0_ovf_prio", 16'hFF00, 8'h00, 2);
    run_op("ovf_edge", 16'h0700, 8'h07, 0);
    run_op("zero_num", 16'h0000, 8'h01, 0);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    dividend = 16'h0064;
    divisor  = 8'h07;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_in_ready", 32'(in_ready), 32'd0);
    chk("t6_busy_valid", 32'(out_valid), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_in_ready", 32'(in_ready), 32'd1);
    chk("t6_reset_outputs", 32'({out_valid, err_div0, err_ovf, quotient, remainder}), 32'd0);
    @(posedge clk); #1;
    chk("t6_reset_held_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t6_rerun", 16'h0064, 8'h07, 0);

    for (int n = 0; n < 3000; n++) begin
      rd = $urandom_range(255, 1);
      rh = $urandom_range(rd - 1, 0);
      rl = $urandom_range(255, 0);
      run_op("rnd", 16'(rh * 256 + rl), 8'(rd), (n % 97 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
